// File: rtl/fir_pkg.sv
// Shared constants, state encoding and address helper for the FIR tap/data sequencer.
package fir_pkg;
  localparam int ADDR_WIDTH = 12;
  localparam int DATA_WIDTH = 32;
  localparam int TAP_NUM    = 11;
  localparam int IDX_W      = $clog2(TAP_NUM);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAP_NUM - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT_IN,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  // Word index to word-aligned byte address.
  function automatic logic [ADDR_WIDTH-1:0] idx2addr(input logic [IDX_W-1:0] idx);
    return {{(ADDR_WIDTH-IDX_W-2){1'b0}}, idx, 2'b00};
  endfunction
endpackage

// File: rtl/fir_tap_data_seq_if.sv
// Sample stream, tap/data RAM ports and MAC pair output of the FIR sequencer.
interface fir_tap_data_seq_if;
  import fir_pkg::*;

  logic                  ss_tvalid;
  logic [DATA_WIDTH-1:0] ss_tdata;
  logic                  ss_tready;

  logic                  data_we;
  logic [ADDR_WIDTH-1:0] data_waddr;
  logic [DATA_WIDTH-1:0] data_wdi;
  logic                  data_re;
  logic [ADDR_WIDTH-1:0] data_raddr;
  logic [DATA_WIDTH-1:0] data_rdo;

  logic                  tap_re;
  logic [ADDR_WIDTH-1:0] tap_raddr;
  logic [DATA_WIDTH-1:0] tap_rdo;

  logic                  mac_valid;
  logic                  mac_first;
  logic                  mac_last;
  logic [DATA_WIDTH-1:0] mac_tap;
  logic [DATA_WIDTH-1:0] mac_data;

  modport master (
    input  ss_tvalid, ss_tdata, data_rdo, tap_rdo,
    output ss_tready, data_we, data_waddr, data_wdi, data_re, data_raddr,
           tap_re, tap_raddr, mac_valid, mac_first, mac_last, mac_tap, mac_data
  );

  modport slave (
    output ss_tvalid, ss_tdata, data_rdo, tap_rdo,
    input  ss_tready, data_we, data_waddr, data_wdi, data_re, data_raddr,
           tap_re, tap_raddr, mac_valid, mac_first, mac_last, mac_tap, mac_data
  );
endinterface

// File: rtl/fir_ring_idx.sv
// Circular-buffer index arithmetic over TAP_NUM entries, without a modulo operator.
module fir_ring_idx
  import fir_pkg::*;
(
  input  logic [IDX_W-1:0] head,
  input  logic [IDX_W-1:0] k,
  output logic [IDX_W-1:0] head_inc,
  output logic [IDX_W-1:0] rd_idx
);
  localparam logic [IDX_W-1:0] DEPTH = IDX_W'(TAP_NUM);

  assign head_inc = (head == LAST_IDX) ? '0 : head + IDX_W'(1);
  // Intermediate may exceed IDX_W bits, but the final result is always < TAP_NUM.
  assign rd_idx   = (head < k) ? head + DEPTH - k : head - k;
endmodule

// File: rtl/fir_tap_data_seq.sv
// Run sequencer: clears the data ring, writes each stream sample at head and
// walks all (tap, data) pairs through the RAM read ports toward the MAC.
module fir_tap_data_seq
  import fir_pkg::*;
(
  input  logic        axis_clk,
  input  logic        axis_rst_n,
  input  logic        ap_start,
  input  logic [31:0] data_length,
  output logic        busy,
  output logic        done,
  fir_tap_data_seq_if.master bus
);
  state_t            state_reg, state_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [IDX_W-1:0]  head_reg, head_next;
  logic [31:0]       count_reg, count_next;
  logic [31:0]       len_reg, len_next;
  logic              mac_valid_reg, mac_first_reg, mac_last_reg;
  logic [IDX_W-1:0]  head_inc, rd_idx;

  fir_ring_idx u_ring_idx (
    .head     (head_reg),
    .k        (idx_reg),
    .head_inc (head_inc),
    .rd_idx   (rd_idx)
  );

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_reg     <= S_IDLE;
      idx_reg       <= '0;
      head_reg      <= '0;
      count_reg     <= '0;
      len_reg       <= '0;
      mac_valid_reg <= 1'b0;
      mac_first_reg <= 1'b0;
      mac_last_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      head_reg      <= head_next;
      count_reg     <= count_next;
      len_reg       <= len_next;
      // RAM reads have one cycle of latency; the flags follow the pair they tag.
      mac_valid_reg <= (state_reg == S_READ);
      mac_first_reg <= (state_reg == S_READ) && (idx_reg == '0);
      mac_last_reg  <= (state_reg == S_READ) && (idx_reg == LAST_IDX);
    end
  end

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    head_next      = head_reg;
    count_next     = count_reg;
    len_next       = len_reg;
    busy           = (state_reg != S_IDLE);
    done           = (state_reg == S_DONE);
    bus.ss_tready  = 1'b0;
    bus.data_we    = 1'b0;
    bus.data_waddr = '0;
    bus.data_wdi   = '0;
    bus.data_re    = 1'b0;
    bus.data_raddr = '0;
    bus.tap_re     = 1'b0;
    bus.tap_raddr  = '0;

    case (state_reg)
      S_IDLE: begin
        if (ap_start) begin
          len_next   = data_length;
          count_next = '0;
          head_next  = '0;
          idx_next   = '0;
          state_next = S_CLEAR;
        end
      end
      S_CLEAR: begin
        bus.data_we    = 1'b1;
        bus.data_waddr = idx2addr(idx_reg);
        if (idx_reg == LAST_IDX) begin
          idx_next   = '0;
          state_next = (len_reg == '0) ? S_DONE : S_WAIT_IN;
        end else begin
          idx_next = idx_reg + IDX_W'(1);
        end
      end
      S_WAIT_IN: begin
        bus.ss_tready = 1'b1;
        if (bus.ss_tvalid) begin
          bus.data_we    = 1'b1;
          bus.data_waddr = idx2addr(head_reg);
          bus.data_wdi   = bus.ss_tdata;
          idx_next       = '0;
          state_next     = S_READ;
        end
      end
      S_READ: begin
        bus.tap_re     = 1'b1;
        bus.data_re    = 1'b1;
        bus.tap_raddr  = idx2addr(idx_reg);
        bus.data_raddr = idx2addr(rd_idx);
        if (idx_reg == LAST_IDX) begin
          idx_next   = '0;
          state_next = S_DRAIN;
        end else begin
          idx_next = idx_reg + IDX_W'(1);
        end
      end
      S_DRAIN: begin
        head_next  = head_inc;
        count_next = count_reg + 32'd1;
        state_next = (count_reg + 32'd1 == len_reg) ? S_DONE : S_WAIT_IN;
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign bus.mac_valid = mac_valid_reg;
  assign bus.mac_first = mac_first_reg;
  assign bus.mac_last  = mac_last_reg;
  assign bus.mac_tap   = bus.tap_rdo;
  assign bus.mac_data  = bus.data_rdo;
endmodule
